// File: rtl/ram_hex_uart_dump.sv
// Drains RAM words 0..LAST_ADDR to an 8N1 UART as four uppercase hex digits plus CR LF per word.
// The RAM read port is driven only while busy; the external address mux gives the CPU priority.
module ram_hex_uart_dump #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 6,
  parameter int LAST_ADDR    = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       data_from_ram,
  output logic              read_enable_to_ram,
  output logic [ADDR_W-1:0] address_to_ram,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, LATCH, LOAD, TX_START, TX_DATA, TX_STOP, DONE_ST
  } state_t;

  state_t           state;
  logic [15:0]      word;
  logic [2:0]       char_idx;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [CNT_W-1:0] clk_cnt;
  logic [7:0]       next_char;
  logic             bit_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    next_char = 8'h0A;
    case (char_idx)
      3'd0:    next_char = hex_ascii(word[15:12]);
      3'd1:    next_char = hex_ascii(word[11:8]);
      3'd2:    next_char = hex_ascii(word[7:4]);
      3'd3:    next_char = hex_ascii(word[3:0]);
      3'd4:    next_char = 8'h0D;
      default: next_char = 8'h0A;
    endcase
  end

  // Bit timer wraps on every bit boundary so timing never accumulates drift.
  assign bit_end = (clk_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      word               <= 16'h0000;
      char_idx           <= 3'd0;
      bit_idx            <= 3'd0;
      shift              <= 8'h00;
      clk_cnt            <= '0;
      read_enable_to_ram <= 1'b0;
      address_to_ram     <= '0;
      uart_tx            <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy               <= 1'b1;
            address_to_ram     <= '0;
            read_enable_to_ram <= 1'b1;
            state              <= RD_REQ;
          end
        end
        RD_REQ: begin
          read_enable_to_ram <= 1'b0;
          state              <= LATCH;
        end
        LATCH: begin
          word     <= data_from_ram;
          char_idx <= 3'd0;
          state    <= LOAD;
        end
        LOAD: begin
          shift   <= next_char;
          bit_idx <= 3'd0;
          clk_cnt <= '0;
          uart_tx <= 1'b0;
          state   <= TX_START;
        end
        TX_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            uart_tx <= shift[0];
            state   <= TX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (char_idx < 3'd5) begin
              char_idx <= char_idx + 3'd1;
              state    <= LOAD;
            end else if (address_to_ram != ADDR_LAST) begin
              // Advance only once the CR LF of the current word has left the line.
              address_to_ram     <= address_to_ram + ADDR_W'(1);
              read_enable_to_ram <= 1'b1;
              state              <= RD_REQ;
            end else begin
              done  <= 1'b1;
              state <= DONE_ST;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        DONE_ST: begin
          busy           <= 1'b0;
          address_to_ram <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_hex_uart_dump.sv
// Directed bench: two instances (LAST_ADDR=1 and LAST_ADDR=0) share clock and reset; a UART
// monitor decodes the selected line, records gaps, read requests and done pulses.
module tb_ram_hex_uart_dump;

  localparam int CPB = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a, start_b;
  logic [15:0] rdata_a, rdata_b;
  logic        rd_en_a, rd_en_b;
  logic [5:0]  addr_a, addr_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [15:0] ram_a [64];
  logic [15:0] ram_b [64];

  ram_hex_uart_dump #(.CLKS_PER_BIT(CPB), .ADDR_W(6), .LAST_ADDR(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data_from_ram(rdata_a),
    .read_enable_to_ram(rd_en_a), .address_to_ram(addr_a), .uart_tx(tx_a),
    .busy(busy_a), .done(done_a)
  );

  ram_hex_uart_dump #(.CLKS_PER_BIT(CPB), .ADDR_W(6), .LAST_ADDR(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data_from_ram(rdata_b),
    .read_enable_to_ram(rd_en_b), .address_to_ram(addr_b), .uart_tx(tx_b),
    .busy(busy_b), .done(done_b)
  );

  // RAM models: one-cycle synchronous read
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= ram_a[addr_a];
    if (rd_en_b) rdata_b <= ram_b[addr_b];
  end

  // Monitor on the selected instance
  logic       mon_sel = 1'b0;
  logic       mon_tx, mon_rd, mon_done, mon_busy;
  logic [5:0] mon_addr;
  assign mon_tx   = mon_sel ? tx_b   : tx_a;
  assign mon_rd   = mon_sel ? rd_en_b : rd_en_a;
  assign mon_done = mon_sel ? done_b : done_a;
  assign mon_busy = mon_sel ? busy_b : busy_a;
  assign mon_addr = mon_sel ? addr_b : addr_a;

  int          mon_cnt  = 0;
  int          high_run = 0;
  int          done_cnt = 0;
  logic [39:0] frame;
  logic [7:0]  mon_byte;
  bit          mon_bad;
  logic [7:0]  rx_q[$];
  bit          shape_q[$];
  int          gap_q[$];
  int          start_cyc_q[$];
  int          rd_addr_q[$];

  always @(negedge clk) begin
    if (mon_rd === 1'b1) rd_addr_q.push_back(int'(mon_addr));
    if (mon_done === 1'b1) done_cnt++;
    if (mon_cnt == 0) begin
      if (mon_tx === 1'b0) begin
        gap_q.push_back(high_run);
        start_cyc_q.push_back(cyc);
        frame[0] = 1'b0;
        mon_cnt  = 1;
      end else begin
        high_run++;
      end
    end else begin
      frame[mon_cnt] = mon_tx;
      mon_cnt++;
      if (mon_cnt == 40) begin
        mon_bad = 1'b0;
        for (int k = 0; k < 10; k++)
          for (int j = 1; j < 4; j++)
            if (frame[4*k+j] !== frame[4*k]) mon_bad = 1'b1;
        if (frame[0] !== 1'b0 || frame[36] !== 1'b1) mon_bad = 1'b1;
        for (int k = 0; k < 8; k++) mon_byte[k] = frame[4*(k+1)];
        rx_q.push_back(mon_byte);
        shape_q.push_back(mon_bad);
        mon_cnt  = 0;
        high_run = 0;
      end
    end
  end

  // Scoreboard
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         base_rx, base_sc, base_rd, base_done, t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (mon_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic mark_bases();
    base_rx   = rx_q.size();
    base_sc   = start_cyc_q.size();
    base_rd   = rd_addr_q.size();
    base_done = done_cnt;
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, 32'(rx_q.size() - base_rx), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check({tag, "_byte"}, 32'(rx_q[base_rx+i]), 32'(exp_q[i]));
      check({tag, "_shape"}, 32'(shape_q[base_rx+i]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ram_a[i] = 16'h0000;
      ram_b[i] = 16'h0000;
    end
    ram_a[0] = 16'h1A2F;
    ram_a[1] = 16'h00C9;
    ram_b[0] = 16'hFFFF;
    repeat (3) tick();
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_rd_en", 32'(rd_en_a), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    reset = 1'b0;

    // Idle for 50 cycles with start low
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_tx", 32'(tx_a), 32'd1);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_rd_en", 32'(rd_en_a), 32'd0);
      check("idle_addr", 32'(addr_a), 32'd0);
    end

    // Two-word dump with a start pulse
    mark_bases();
    exp_q = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A,
              8'h30, 8'h30, 8'h43, 8'h39, 8'h0D, 8'h0A};
    start_a = 1'b1;
    t0 = cyc;
    tick();
    start_a = 1'b0;
    check("rdreq_busy", 32'(busy_a), 32'd1);
    check("rdreq_rd_en", 32'(rd_en_a), 32'd1);
    check("rdreq_addr", 32'(addr_a), 32'd0);
    wait_done("dump1_timeout", 2000);
    check("dump1_busy_at_done", 32'(busy_a), 32'd1);
    tick();
    check("dump1_done_pulse", 32'(done_a), 32'd0);
    check("dump1_busy_after", 32'(busy_a), 32'd0);
    tick();
    check_bytes("dump1");
    check("dump1_latency", 32'(start_cyc_q[base_sc] - t0), 32'd4);
    for (int i = 1; i < 12; i++)
      check("dump1_gap", 32'(gap_q[base_sc+i]), (i == 6) ? 32'd3 : 32'd1);
    check("dump1_rd_count", 32'(rd_addr_q.size() - base_rd), 32'd2);
    check("dump1_rd_addr0", 32'(rd_addr_q[base_rd]), 32'd0);
    check("dump1_rd_addr1", 32'(rd_addr_q[base_rd+1]), 32'd1);
    check("dump1_done_count", 32'(done_cnt - base_done), 32'd1);

    // Start held high: one dump, one idle cycle, then a restart from address 0
    mark_bases();
    start_a = 1'b1;
    wait_done("held_timeout", 2000);
    check("held_busy_at_done", 32'(busy_a), 32'd1);
    tick();
    check("held_idle_busy", 32'(busy_a), 32'd0);
    check("held_idle_done", 32'(done_a), 32'd0);
    tick();
    check("held_restart_busy", 32'(busy_a), 32'd1);
    check("held_restart_rd_en", 32'(rd_en_a), 32'd1);
    check("held_restart_addr", 32'(addr_a), 32'd0);
    start_a = 1'b0;
    check_bytes("held");
    check("held_done_count", 32'(done_cnt - base_done), 32'd1);
    check("held_rd_count", 32'(rd_addr_q.size() - base_rd), 32'd3);
    check("held_rd_restart", 32'(rd_addr_q[base_rd+2]), 32'd0);

    // Async reset during bit 0 of character 2 ('2' = 8'h32, bit 0 = 0) of the restarted dump
    begin
      int n = 0;
      while (start_cyc_q.size() <= base_sc + 14 && n < 600) begin
        tick();
        n++;
      end
      check("char2_timeout", 32'(n < 600), 32'd1);
    end
    repeat (5) tick();
    check("mid_bit0_low", 32'(tx_a), 32'd0);
    reset = 1'b1;
    #1;
    check("arst_tx", 32'(tx_a), 32'd1);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_rd_en", 32'(rd_en_a), 32'd0);
    check("arst_addr", 32'(addr_a), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (60) tick();

    // Dump after reset starts over from address 0
    mark_bases();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done("redump_timeout", 2000);
    repeat (2) tick();
    check_bytes("redump");
    check("redump_rd_count", 32'(rd_addr_q.size() - base_rd), 32'd2);
    check("redump_rd_addr0", 32'(rd_addr_q[base_rd]), 32'd0);

    // LAST_ADDR=0 instance: a single word
    mon_sel = 1'b1;
    tick();
    mark_bases();
    exp_q = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    start_b = 1'b1;
    t0 = cyc;
    tick();
    start_b = 1'b0;
    wait_done("single_timeout", 1000);
    check("single_busy_at_done", 32'(busy_b), 32'd1);
    tick();
    check("single_done_pulse", 32'(done_b), 32'd0);
    check("single_busy_after", 32'(busy_b), 32'd0);
    tick();
    check_bytes("single");
    check("single_latency", 32'(start_cyc_q[base_sc] - t0), 32'd4);
    for (int i = 1; i < 6; i++)
      check("single_gap", 32'(gap_q[base_sc+i]), 32'd1);
    check("single_rd_count", 32'(rd_addr_q.size() - base_rd), 32'd1);
    check("single_rd_addr", 32'(rd_addr_q[base_rd]), 32'd0);
    check("single_done_count", 32'(done_cnt - base_done), 32'd1);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
